// File: rtl/flags.sv
// Carry/Zero status flags with a one-deep shadow copy for interrupt save/restore.
// Outputs come straight from the flag registers; every update happens on the rising clock edge.
module flags (
    input  logic clk,
    input  logic rst,
    input  logic c_in,
    input  logic z_in,
    input  logic flg_c_set,
    input  logic flg_c_clr,
    input  logic flg_c_ld,
    input  logic flg_z_ld,
    input  logic flg_ld_sel,
    input  logic flg_shad_ld,
    output logic c_out,
    output logic z_out
);

    logic c_q, c_d;
    logic z_q, z_d;
    logic shad_c_q, shad_c_d;
    logic shad_z_q, shad_z_d;
    logic src_c, src_z;

    // The mux and all next-state terms use pre-edge state, so a save combined with a
    // restore swaps the flags and the shadow copy in a single cycle.
    always_comb begin
        src_c = flg_ld_sel ? shad_c_q : c_in;
        src_z = flg_ld_sel ? shad_z_q : z_in;

        c_d = c_q;
        if (flg_c_clr) begin
            c_d = 1'b0;
        end else if (flg_c_set) begin
            c_d = 1'b1;
        end else if (flg_c_ld) begin
            c_d = src_c;
        end

        z_d = z_q;
        if (flg_z_ld) begin
            z_d = src_z;
        end

        shad_c_d = shad_c_q;
        shad_z_d = shad_z_q;
        if (flg_shad_ld) begin
            shad_c_d = c_q;
            shad_z_d = z_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q      <= 1'b0;
            z_q      <= 1'b0;
            shad_c_q <= 1'b0;
            shad_z_q <= 1'b0;
        end else begin
            c_q      <= c_d;
            z_q      <= z_d;
            shad_c_q <= shad_c_d;
            shad_z_q <= shad_z_d;
        end
    end

    assign c_out = c_q;
    assign z_out = z_q;

endmodule

// File: tb/tb_flags.sv
// Directed bench for the flags block; the shadow copy is observed through later restores.
module tb_flags;

    logic clk;
    logic rst;
    logic c_in;
    logic z_in;
    logic flg_c_set;
    logic flg_c_clr;
    logic flg_c_ld;
    logic flg_z_ld;
    logic flg_ld_sel;
    logic flg_shad_ld;
    logic c_out;
    logic z_out;

    int checks;
    int failures;

    flags dut (
        .clk         (clk),
        .rst         (rst),
        .c_in        (c_in),
        .z_in        (z_in),
        .flg_c_set   (flg_c_set),
        .flg_c_clr   (flg_c_clr),
        .flg_c_ld    (flg_c_ld),
        .flg_z_ld    (flg_z_ld),
        .flg_ld_sel  (flg_ld_sel),
        .flg_shad_ld (flg_shad_ld),
        .c_out       (c_out),
        .z_out       (z_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of inputs across one rising edge, then compare both flags.
    task automatic step(input string tag,
                        input logic r, input logic ci, input logic zi,
                        input logic cset, input logic cclr, input logic cld,
                        input logic zld, input logic sel, input logic shad,
                        input logic exp_c, input logic exp_z);
        rst = r; c_in = ci; z_in = zi;
        flg_c_set = cset; flg_c_clr = cclr; flg_c_ld = cld;
        flg_z_ld = zld; flg_ld_sel = sel; flg_shad_ld = shad;
        @(posedge clk);
        #1;
        checks++;
        assert (c_out === exp_c) else begin
            failures++;
            $error("FAIL %s c_out observed=%b expected=%b", tag, c_out, exp_c);
        end
        checks++;
        assert (z_out === exp_z) else begin
            failures++;
            $error("FAIL %s z_out observed=%b expected=%b", tag, z_out, exp_z);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0; c_in = 1'b0; z_in = 1'b0;
        flg_c_set = 1'b0; flg_c_clr = 1'b0; flg_c_ld = 1'b0;
        flg_z_ld = 1'b0; flg_ld_sel = 1'b0; flg_shad_ld = 1'b0;
        #2;
        //            tag              rst ci zi set clr cld zld sel shd  C  Z
        step("reset_all_strobes",      1, 1, 1, 1,  1,  1,  1,  1,  1,  0, 0);
        step("restore_reset_shadow",   0, 1, 1, 0,  0,  1,  1,  1,  0,  0, 0);
        step("load_from_alu",          0, 1, 1, 0,  0,  1,  1,  0,  0,  1, 1);
        step("hold",                   0, 0, 0, 0,  0,  0,  0,  0,  0,  1, 1);
        step("save",                   0, 0, 0, 0,  0,  0,  0,  0,  1,  1, 1);
        step("clear_c",                0, 0, 0, 0,  1,  0,  0,  0,  0,  0, 1);
        step("restore_1_1",            0, 0, 0, 0,  0,  1,  1,  1,  0,  1, 1);
        step("clr_beats_set_ld",       0, 1, 0, 1,  1,  1,  0,  0,  0,  0, 1);
        step("set_beats_ld",           0, 0, 0, 1,  0,  1,  0,  0,  0,  1, 1);
        step("clear_for_save_load",    0, 0, 0, 0,  1,  0,  0,  0,  0,  0, 1);
        step("save_and_load",          0, 1, 0, 0,  0,  1,  1,  0,  1,  1, 0);
        step("restore_old_0_1",        0, 1, 0, 0,  0,  1,  1,  1,  0,  0, 1);
        step("load_1_0",               0, 1, 0, 0,  0,  1,  1,  0,  0,  1, 0);
        step("swap",                   0, 1, 0, 0,  0,  1,  1,  1,  1,  0, 1);
        step("restore_after_swap",     0, 0, 1, 0,  0,  1,  1,  1,  0,  1, 0);
        step("sel_without_load",       0, 0, 1, 0,  0,  0,  0,  1,  0,  1, 0);
        step("z_load_only",            0, 0, 1, 0,  0,  0,  1,  0,  0,  1, 1);
        step("save_1_1",               0, 0, 0, 0,  0,  0,  0,  0,  1,  1, 1);
        step("reset_mid_run",          1, 1, 1, 1,  0,  1,  1,  0,  1,  0, 0);
        step("restore_after_reset",    0, 1, 1, 0,  0,  1,  1,  1,  0,  0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
